// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the ram256x8 port sequencer: FSM states, requester IDs,
// access size codes and R/W polarity.
`timescale 1ns/1ps
package mem_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

  localparam logic [2:0] MS_BYTE = 3'b000;
  localparam logic [2:0] MS_HALF = 3'b001;
  localparam logic [2:0] MS_WORD = 3'b010;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic port_id_e other_port(input port_id_e id);
    return (id == PORT_F) ? PORT_D : PORT_F;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-way round-robin pick between fetch and data requesters; purely combinational.
`timescale 1ns/1ps
module mem_arb_pick
  import mem_arb_defs::*;
(
  input  logic     f_req,
  input  logic     d_req,
  input  port_id_e last_grant,
  output logic     grant_valid,
  output port_id_e grant_id
);

  // winner selection: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    grant_valid = f_req | d_req;
    grant_id    = PORT_F;
    case ({f_req, d_req})
      2'b10:   grant_id = PORT_F;
      2'b01:   grant_id = PORT_D;
      2'b11:   grant_id = other_port(last_grant);
      default: grant_id = PORT_F;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer sharing the single ram port between fetch (F) and data (D) requesters
// using the MOV/MOC four-phase handshake; all outputs come straight from flops.
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          F_REQ,
  input  logic [AW-1:0] F_ADDR,
  output logic          F_DONE,
  output logic [DW-1:0] F_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [2:0]    D_MS,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_WDATA,
  output logic          D_DONE,
  output logic [DW-1:0] D_RDATA,
  output logic          ERR,
  output logic          MOV,
  output logic          RW,
  output logic [2:0]    MS,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] DIN,
  input  logic          MOC,
  input  logic [DW-1:0] DOUT
);

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  port_id_e      last_grant_q, last_grant_d;
  port_id_e      win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mov_q, mov_d;
  logic          rw_q, rw_d;
  logic [2:0]    ms_q, ms_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          f_done_q, f_done_d;
  logic          d_done_q, d_done_d;
  logic          err_q, err_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic          grant_valid_s;
  port_id_e      grant_id_s;

  mem_arb_pick u_pick (
    .f_req       (F_REQ),
    .d_req       (D_REQ),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // next-state and next-output logic for the IDLE/WAIT/DONE sequence
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    mov_d        = mov_q;
    rw_d         = rw_q;
    ms_d         = ms_q;
    addr_d       = addr_q;
    din_d        = din_q;
    f_done_d     = 1'b0;
    d_done_d     = 1'b0;
    err_d        = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CW{1'b0}};
        // a MOC still high from the ram blocks the grant until it has dropped
        if (grant_valid_s && !MOC) begin
          state_d      = ST_WAIT;
          mov_d        = 1'b1;
          win_d        = grant_id_s;
          last_grant_d = grant_id_s;
          if (grant_id_s == PORT_F) begin
            rw_d   = RW_READ;
            ms_d   = MS_WORD;
            addr_d = F_ADDR;
          end else begin
            rw_d   = D_RW;
            ms_d   = D_MS;
            addr_d = D_ADDR;
            din_d  = D_WDATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (MOC) begin
          state_d = ST_DONE;
          mov_d   = 1'b0;
          if (win_q == PORT_F) begin
            f_done_d  = 1'b1;
            f_rdata_d = DOUT;
          end else begin
            d_done_d = 1'b1;
            if (rw_q == RW_READ) begin
              d_rdata_d = DOUT;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          mov_d   = 1'b0;
          err_d   = 1'b1;
          if (win_q == PORT_F) begin
            f_done_d = 1'b1;
          end else begin
            d_done_d = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        cnt_d = {CW{1'b0}};
        // a late MOC after an abort is absorbed here, not by the next access
        if (!MOC) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        mov_d   = 1'b0;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // state, counter and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_F;
      win_q        <= PORT_F;
      cnt_q        <= {CW{1'b0}};
      mov_q        <= 1'b0;
      rw_q         <= RW_READ;
      ms_q         <= MS_WORD;
      addr_q       <= {AW{1'b0}};
      din_q        <= {DW{1'b0}};
      f_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
      f_rdata_q    <= {DW{1'b0}};
      d_rdata_q    <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      mov_q        <= mov_d;
      rw_q         <= rw_d;
      ms_q         <= ms_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      f_done_q     <= f_done_d;
      d_done_q     <= d_done_d;
      err_q        <= err_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign F_DONE  = f_done_q;
  assign F_RDATA = f_rdata_q;
  assign D_DONE  = d_done_q;
  assign D_RDATA = d_rdata_q;
  assign ERR     = err_q;
  assign MOV     = mov_q;
  assign RW      = rw_q;
  assign MS      = ms_q;
  assign ADDR    = addr_q;
  assign DIN     = din_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: plays both requesters and the ram, and checks every
// access against a transaction-level model of arbitration, latency and read data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_rw, moc;
  logic [2:0]  d_ms;
  logic [31:0] f_addr, d_addr, d_wdata, dout;
  logic        f_done, d_done, err, mov, rw;
  logic [2:0]  ms;
  logic [31:0] f_rdata, d_rdata, addr, din;

  int          n_errors = 0;
  int          n_checks = 0;

  // reference model state
  bit          m_last;
  logic [31:0] m_f_rdata, m_d_rdata;

  mem_port_arbiter #(.DW(32), .AW(32), .TIMEOUT(TIMEOUT), .CW(4)) dut (
    .CLK(clk), .RESET(reset),
    .F_REQ(f_req), .F_ADDR(f_addr), .F_DONE(f_done), .F_RDATA(f_rdata),
    .D_REQ(d_req), .D_RW(d_rw), .D_MS(d_ms), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_DONE(d_done), .D_RDATA(d_rdata), .ERR(err),
    .MOV(mov), .RW(rw), .MS(ms), .ADDR(addr), .DIN(din),
    .MOC(moc), .DOUT(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_f_cmd();
    f_addr = $urandom;
  endtask

  task automatic new_d_cmd();
    d_rw    = 1'($urandom_range(1, 0));
    d_ms    = 3'($urandom_range(2, 0));
    d_addr  = $urandom;
    d_wdata = $urandom;
  endtask

  // One full access from the grant edge to the return to IDLE.
  // k < 0: ram never answers (timeout); otherwise MOC rises k cycles after MOV.
  // h: extra cycles MOC stays high after completion (late MOC after a timeout).
  task automatic serve_one(input int k, input int h, input logic [31:0] rd,
                           input bit drop_early, input bit rereq);
    bit          w;
    bit          to;
    int          n_wait;
    logic        rw_e;
    logic [2:0]  ms_e;
    logic [31:0] addr_e, din_e;
    w = (f_req && d_req) ? !m_last : d_req;
    if (!w) begin
      rw_e = 1'b1; ms_e = 3'b010; addr_e = f_addr; din_e = 32'h0;
    end else begin
      rw_e = d_rw; ms_e = d_ms; addr_e = d_addr; din_e = d_wdata;
    end
    to = (k < 0);

    tick();
    m_last = w;
    chk("grant_mov", 64'(mov), 64'(1'b1));
    chk("grant_rw", 64'(rw), 64'(rw_e));
    chk("grant_ms", 64'(ms), 64'(ms_e));
    chk("grant_addr", 64'(addr), 64'(addr_e));
    if (w) chk("grant_din", 64'(din), 64'(din_e));
    if (drop_early) begin
      if (w) d_req = 1'b0; else f_req = 1'b0;
    end

    n_wait = to ? TIMEOUT - 1 : k;
    for (int i = 0; i < n_wait; i++) begin
      tick();
      chk("wait_mov", 64'(mov), 64'(1'b1));
      chk("wait_addr", 64'(addr), 64'(addr_e));
      chk("wait_quiet", 64'({f_done, d_done, err}), 64'(3'b000));
    end
    if (!to) begin
      moc  = 1'b1;
      dout = rd;
    end

    tick();
    if (!to) begin
      if (!w) m_f_rdata = rd;
      else if (rw_e) m_d_rdata = rd;
    end
    chk("done_mov", 64'(mov), 64'(1'b0));
    chk("f_done", 64'(f_done), 64'(!w));
    chk("d_done", 64'(d_done), 64'(w));
    chk("err", 64'(err), 64'(to));
    chk("f_rdata", 64'(f_rdata), 64'(m_f_rdata));
    chk("d_rdata", 64'(d_rdata), 64'(m_d_rdata));

    if (w) begin
      d_req = rereq;
      if (rereq) new_d_cmd();
    end else begin
      f_req = rereq;
      if (rereq) new_f_cmd();
    end
    if (to && h > 0) moc = 1'b1;
    for (int i = 0; i < h; i++) begin
      tick();
      chk("hold_quiet", 64'({mov, f_done, d_done, err}), 64'(4'b0000));
    end
    moc  = 1'b0;
    dout = $urandom;
    tick();
    chk("release_quiet", 64'({mov, f_done, d_done, err}), 64'(4'b0000));
  endtask

  initial begin
    logic [1:0] sel;
    int         kk;
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; moc = 1'b0;
    d_rw = 1'b1; d_ms = 3'b010; f_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; dout = 32'h0;
    m_last = 1'b0; m_f_rdata = 32'h0; m_d_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_mov", 64'(mov), 64'(1'b0));
    chk("rst_rw", 64'(rw), 64'(1'b1));
    chk("rst_ms", 64'(ms), 64'(3'b010));
    chk("rst_addr", 64'(addr), 64'(32'h0));
    chk("rst_din", 64'(din), 64'(32'h0));
    chk("rst_pulses", 64'({f_done, d_done, err}), 64'(3'b000));
    chk("rst_rdata", {f_rdata, d_rdata}, 64'h0);

    // fetch only, MOC two cycles after MOV
    f_req = 1'b1; f_addr = 32'h10;
    serve_one(2, 0, 32'hE09C802C, 1'b0, 1'b0);

    // byte write from the data port
    d_req = 1'b1; d_rw = 1'b0; d_ms = 3'b000; d_addr = 32'h20; d_wdata = 32'hAB;
    serve_one(1, 0, 32'h5555AAAA, 1'b0, 1'b0);

    // both requesting continuously: grants must alternate
    f_req = 1'b1; new_f_cmd();
    d_req = 1'b1; new_d_cmd();
    for (int i = 0; i < 4; i++) serve_one(0, 0, $urandom, 1'b0, 1'b1);
    f_req = 1'b0; d_req = 1'b0;

    // ram never answers a data access; the following fetch still proceeds
    d_req = 1'b1; d_rw = 1'b1; d_ms = 3'b010; d_addr = 32'h40;
    serve_one(-1, 0, 32'h0, 1'b0, 1'b0);
    f_req = 1'b1; new_f_cmd();
    serve_one(1, 0, 32'h12345678, 1'b0, 1'b0);

    // reset in the middle of a wait aborts silently
    f_req = 1'b1; new_f_cmd();
    tick();
    chk("pre_rst_mov", 64'(mov), 64'(1'b1));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_last = 1'b0; m_f_rdata = 32'h0; m_d_rdata = 32'h0;
    chk("abort_quiet", 64'({mov, f_done, d_done, err}), 64'(4'b0000));
    chk("abort_rdata", {f_rdata, d_rdata}, 64'h0);
    new_f_cmd();
    serve_one(2, 0, 32'hCAFEF00D, 1'b0, 1'b0);

    // MOC held 4 extra cycles with the other port waiting
    f_req = 1'b1; new_f_cmd();
    d_req = 1'b1; new_d_cmd();
    serve_one(0, 4, $urandom, 1'b0, 1'b0);
    serve_one(0, 0, $urandom, 1'b0, 1'b0);

    // late MOC after a timeout
    f_req = 1'b1; new_f_cmd();
    serve_one(-1, 3, 32'h0, 1'b0, 1'b0);

    for (int it = 0; it < 150; it++) begin
      if (!f_req && !d_req) begin
        if ($urandom_range(3, 0) == 0) begin
          tick();
          chk("idle_mov", 64'(mov), 64'(1'b0));
        end
        sel = 2'($urandom_range(3, 1));
        if (sel[0]) begin new_f_cmd(); f_req = 1'b1; end
        if (sel[1]) begin new_d_cmd(); d_req = 1'b1; end
      end else begin
        if (!f_req && $urandom_range(1, 0) == 1) begin new_f_cmd(); f_req = 1'b1; end
        if (!d_req && $urandom_range(1, 0) == 1) begin new_d_cmd(); d_req = 1'b1; end
      end
      kk = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(4, 0));
      serve_one(kk, int'($urandom_range(3, 0)), $urandom,
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
